// File: rtl/fir_mac_pkg.sv
// Shared definitions for the FIR multiply-accumulate stage: FSM encoding,
// default geometry and the Q-format constants for the coefficient table.
package fir_mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_FLUSH = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  localparam int M_DEF         = 4;
  localparam int ADDR_SIZE_DEF = 5;
  localparam int DATA_SIZE_DEF = 12;
  localparam int COEF_SIZE_DEF = 16;
  localparam int FRAC_BITS_DEF = 15;
  localparam int ACC_SIZE_DEF  = 32;
  localparam int OUT_SIZE_DEF  = 12;

  // +1.0 in Q1.FRAC_BITS; one bit wider than the signed write format can express.
  localparam int COEF_UNITY = 32'sd1 << FRAC_BITS_DEF;

endpackage

// File: rtl/fir_coef_ram.sv
// M-entry coefficient register file: one write port, one combinational read port.
// Entries carry one extra bit so the reset value +1.0 (passthrough) is representable.
module fir_coef_ram
  import fir_mac_pkg::*;
#(
  parameter int M         = M_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int COEF_SIZE = COEF_SIZE_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ADDR_SIZE-1:0]        waddr,
  input  logic signed [COEF_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0]        raddr,
  output logic signed [COEF_SIZE:0]   rdata
);

  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [ADDR_SIZE:0] M_LIM = (ADDR_SIZE+1)'(M);
  localparam logic signed [COEF_SIZE:0] UNITY = (COEF_SIZE+1)'(1) <<< FRAC_BITS;

  logic signed [COEF_SIZE:0] mem_q [M];
  logic signed [COEF_SIZE:0] mem_d [M];
  logic                      wr_ok_s;
  logic                      rd_ok_s;

  assign wr_ok_s = we && ({1'b0, waddr} < M_LIM);
  assign rd_ok_s = ({1'b0, raddr} < M_LIM);

  // Next table contents: only the addressed in-range entry takes the write.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      mem_d[i] = (wr_ok_s && (waddr[IDX_W-1:0] == IDX_W'(i))) ?
                 {wdata[COEF_SIZE-1], wdata} : mem_q[i];
    end
  end

  // Table storage, reset to a single unity tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M; i++) begin
        mem_q[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      for (int i = 0; i < M; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = rd_ok_s ? mem_q[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/fir_mac.sv
// FIR multiply-accumulate stage: multiplies the buffer's write-out stream by the
// coefficient table, accumulates a window, then rounds/saturates one output sample.
module fir_mac
  import fir_mac_pkg::*;
#(
  parameter int M         = M_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int COEF_SIZE = COEF_SIZE_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_SIZE  = ACC_SIZE_DEF,
  parameter int OUT_SIZE  = OUT_SIZE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        owe,
  input  logic [ADDR_SIZE-1:0]        addr,
  input  logic [DATA_SIZE-1:0]        di,
  input  logic                        done,
  input  logic                        coef_we,
  input  logic [ADDR_SIZE-1:0]        coef_addr,
  input  logic signed [COEF_SIZE-1:0] coef_di,
  output logic                        coef_rdy,
  output logic [OUT_SIZE-1:0]         dout,
  output logic                        valid,
  output logic                        sat
);

  localparam int PROD_W = DATA_SIZE + COEF_SIZE + 2;
  localparam logic [ADDR_SIZE:0] M_LIM = (ADDR_SIZE+1)'(M);
  localparam logic signed [ACC_SIZE:0] HALF = (ACC_SIZE+1)'(1) <<< (FRAC_BITS-1);
  localparam logic signed [ACC_SIZE:0] OUT_MAX = (ACC_SIZE+1)'((1 << OUT_SIZE) - 1);

  state_e                     state_q, state_d;
  logic                       flush_cnt_q, flush_cnt_d;
  logic signed [PROD_W-1:0]   p_q, p_d;
  logic                       p_v_q, p_v_d;
  logic                       p_first_q, p_first_d;
  logic signed [ACC_SIZE-1:0] acc_q, acc_d;
  logic [OUT_SIZE-1:0]        dout_q, dout_d;
  logic                       valid_q, valid_d;
  logic                       sat_q, sat_d;
  logic                       coef_rdy_q, coef_rdy_d;

  logic signed [COEF_SIZE:0]  coef_rd_s;
  logic signed [DATA_SIZE:0]  sample_s;
  logic                       addr_zero_s;
  logic                       take_s;
  logic signed [ACC_SIZE-1:0] p_ext_s;
  logic signed [ACC_SIZE:0]   rnd_s;
  logic signed [ACC_SIZE:0]   r_s;

  fir_coef_ram #(
    .M         (M),
    .ADDR_SIZE (ADDR_SIZE),
    .COEF_SIZE (COEF_SIZE),
    .FRAC_BITS (FRAC_BITS)
  ) u_coef_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (coef_we & coef_rdy_q),
    .waddr (coef_addr),
    .wdata (coef_di),
    .raddr (addr),
    .rdata (coef_rd_s)
  );

  // Multiply/accumulate pipe and output rounding.
  always_comb begin
    addr_zero_s = (addr == '0);
    sample_s    = {1'b0, di};
    // A window opens only with tap 0 from idle; flush/out ignore the stream.
    take_s      = owe && ({1'b0, addr} < M_LIM) &&
                  ((state_q == S_ACC) || ((state_q == S_IDLE) && addr_zero_s));
    p_d         = take_s ? (PROD_W'(sample_s) * PROD_W'(coef_rd_s)) : '0;
    p_v_d       = take_s;
    p_first_d   = take_s && addr_zero_s;
    p_ext_s     = ACC_SIZE'(p_q);
    if (p_v_q) begin
      acc_d = p_first_q ? p_ext_s : (acc_q + p_ext_s);
    end else begin
      acc_d = acc_q;
    end
    rnd_s = {acc_q[ACC_SIZE-1], acc_q} + HALF;
    r_s   = rnd_s >>> FRAC_BITS;
  end

  // Window sequencing and output register next-state.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    sat_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (owe && addr_zero_s) begin
          state_d = S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        if (done) begin
          state_d     = S_FLUSH;
          flush_cnt_d = 1'b0;
        end else begin
          state_d = S_ACC;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q) begin
          state_d = S_OUT;
        end else begin
          state_d     = S_FLUSH;
          flush_cnt_d = 1'b1;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        if (r_s[ACC_SIZE]) begin
          dout_d = '0;
          sat_d  = 1'b1;
        end else if (r_s > OUT_MAX) begin
          dout_d = '1;
          sat_d  = 1'b1;
        end else begin
          dout_d = r_s[OUT_SIZE-1:0];
          sat_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    coef_rdy_d = (state_d == S_IDLE);
  end

  // All state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= 1'b0;
      p_q         <= '0;
      p_v_q       <= 1'b0;
      p_first_q   <= 1'b0;
      acc_q       <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
      coef_rdy_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      p_q         <= p_d;
      p_v_q       <= p_v_d;
      p_first_q   <= p_first_d;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      sat_q       <= sat_d;
      coef_rdy_q  <= coef_rdy_d;
    end
  end

  assign coef_rdy = coef_rdy_q;
  assign dout     = dout_q;
  assign valid    = valid_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_fir_mac.sv
// Self-checking bench for fir_mac: directed corner windows plus random windows
// checked against an arithmetic dot-product / round / clip reference.
module tb_fir_mac;

  localparam int M  = 4;
  localparam int AW = 5;
  localparam int DW = 12;
  localparam int CW = 16;
  localparam int OW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          owe;
  logic [AW-1:0] addr;
  logic [DW-1:0] di;
  logic          done;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_di;
  logic          coef_rdy;
  logic [OW-1:0] dout;
  logic          valid;
  logic          sat;

  int     n_checks = 0;
  int     n_errors = 0;
  longint coef_m [M];
  longint acc_m;

  fir_mac dut (
    .clk       (clk),
    .rst       (rst),
    .owe       (owe),
    .addr      (addr),
    .di        (di),
    .done      (done),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_di   (coef_di),
    .coef_rdy  (coef_rdy),
    .dout      (dout),
    .valid     (valid),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint s16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  task automatic reset_model();
    coef_m[0] = 32768;
    for (int i = 1; i < M; i++) coef_m[i] = 0;
    acc_m = 0;
  endtask

  task automatic coef_write(input int a, input int v);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a[AW-1:0];
    coef_di   = v[CW-1:0];
    @(negedge clk);
    coef_we = 1'b0;
    if (a < M) coef_m[a] = s16(v);
  endtask

  task automatic drive(input int a, input int d, input bit dn);
    @(negedge clk);
    owe  = 1'b1;
    addr = a[AW-1:0];
    di   = d[DW-1:0];
    done = dn;
    if (a == 0) acc_m = 0;
    if (a < M) acc_m += longint'(d) * coef_m[a];
  endtask

  // Raise done (unless it rode with the last sample), then check latency, value and pulse shape.
  task automatic finish_win(input bit done_sent, input string tag);
    longint r, exp_d, exp_s;
    int k;
    bit seen;
    if (!done_sent) begin
      @(negedge clk);
      owe  = 1'b0;
      done = 1'b1;
    end
    r = (acc_m + 64'sd16384) >>> 15;
    if (r < 0) begin
      exp_d = 0; exp_s = 1;
    end else if (r > 4095) begin
      exp_d = 4095; exp_s = 1;
    end else begin
      exp_d = r; exp_s = 0;
    end
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      owe  = 1'b0;
      done = 1'b0;
      if (valid === 1'b1) seen = 1'b1;
    end
    check_eq({tag, "_lat"}, k, 4);
    check_eq({tag, "_dout"}, dout, exp_d);
    check_eq({tag, "_sat"}, sat, exp_s);
    @(negedge clk);
    check_eq({tag, "_vdrop"}, valid, 0);
    check_eq({tag, "_satclr"}, sat, 0);
    check_eq({tag, "_hold"}, dout, exp_d);
  endtask

  task automatic run_win(input int d0, input int d1, input int d2, input int d3,
                         input bit dwl, input string tag);
    drive(0, d0, 1'b0);
    drive(1, d1, 1'b0);
    drive(2, d2, 1'b0);
    drive(3, d3, dwl);
    finish_win(dwl, tag);
  endtask

  initial begin
    bit seen_v;
    rst = 1'b1; owe = 1'b0; addr = '0; di = '0; done = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_di = '0;
    reset_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_sat", sat, 0);
    check_eq("rst_rdy", coef_rdy, 1);

    // Passthrough after reset
    run_win(100, 7, 7, 7, 1'b0, "pass");

    // Quarter gain taps, including a 0.75 -> 1 rounding case
    for (int i = 0; i < M; i++) coef_write(i, 32'h2000);
    run_win(400, 400, 400, 400, 1'b0, "q25");
    run_win(1, 1, 1, 0, 1'b1, "q25rnd");

    // Positive overflow
    for (int i = 0; i < M; i++) coef_write(i, 32'h7FFF);
    run_win(4095, 4095, 4095, 4095, 1'b0, "ovf");

    // Negative result clips to zero, then 1.5 rounds to 2
    coef_write(0, 32'h8000);
    for (int i = 1; i < M; i++) coef_write(i, 0);
    run_win(10, 0, 0, 0, 1'b0, "neg");
    coef_write(0, 32'h4000);
    run_win(3, 0, 0, 0, 1'b0, "half");

    // done while idle produces nothing
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    seen_v = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (valid !== 1'b0) seen_v = 1'b1;
    end
    check_eq("idle_done", seen_v, 0);

    // Restarted window, coef write during accumulation, out-of-range tap
    drive(0, 50, 1'b0);
    drive(1, 50, 1'b0);
    drive(0, 8, 1'b0);
    drive(1, 4095, 1'b0);
    coef_we = 1'b1; coef_addr = 5'd1; coef_di = 16'h7FFF;
    check_eq("rdy_acc", coef_rdy, 0);
    drive(5, 4095, 1'b0);
    coef_we = 1'b0;
    drive(2, 0, 1'b0);
    drive(3, 0, 1'b1);
    finish_win(1'b1, "busy");
    coef_write(9, 32'h7FFF);
    run_win(0, 4095, 4095, 4095, 1'b0, "oor");

    // Reset in the middle of a window
    drive(0, 6, 1'b0);
    drive(1, 6, 1'b0);
    @(negedge clk);
    owe = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_dout", dout, 0);
    check_eq("mid_rst_valid", valid, 0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    run_win(1234, 5, 6, 7, 1'b0, "post_rst");

    // Random coefficient sets and windows
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < M; i++) coef_write(i, int'($urandom_range(0, 65535)));
      if ($urandom_range(0, 3) == 0) coef_write(int'($urandom_range(M, 31)), int'($urandom_range(0, 65535)));
      run_win(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              1'($urandom_range(0, 1)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
